// File: rtl/text_string_renderer.sv
// Glyph-string sequencer for the 8x16 font ROM: scans every glyph pixel and
// issues registered, screen-clipped framebuffer plot requests one per clock.
module text_string_renderer #(
    parameter int MAX_CHARS = 8,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             num_chars,
    input  logic [4*MAX_CHARS-1:0] text,
    input  logic [7:0]             origin_x,
    input  logic [6:0]             origin_y,
    input  logic [2:0]             fg_colour,
    input  logic [2:0]             bg_colour,
    input  logic                   opaque,
    output logic [3:0]             rom_letter,
    output logic [7:0]             rom_x,
    output logic [6:0]             rom_y,
    input  logic                   rom_pixel,
    output logic                   busy,
    output logic                   plot,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             colour,
    output logic                   done
);

    localparam int IDX_W = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]       char_q;
    logic [2:0]             col_q;
    logic [3:0]             row_q;
    logic [3:0]             count_l;
    logic [4*MAX_CHARS-1:0] text_l;
    logic [7:0]             ox_l;
    logic [6:0]             oy_l;
    logic [2:0]             fg_l;
    logic [2:0]             bg_l;
    logic                   opaque_l;

    logic [3:0] num_clamped;
    logic       accept;
    logic       last_pixel;
    logic       in_draw;
    logic [9:0] sx;
    logic [7:0] sy;
    logic       on_screen;

    assign num_clamped = (num_chars > 4'(MAX_CHARS)) ? 4'(MAX_CHARS) : num_chars;
    assign accept      = (state == IDLE) && start && (num_clamped != 4'd0);
    assign in_draw     = (state == DRAW);
    assign last_pixel  = (4'(char_q) == count_l - 4'd1) && (row_q == 4'd15) && (col_q == 3'd7);

    // Screen coordinates are formed wide enough that a right-hand glyph never
    // wraps back onto the left edge; clipping happens on the wide value.
    assign sx        = 10'(ox_l) + 10'({char_q, 3'b000}) + 10'(col_q);
    assign sy        = 8'(oy_l) + 8'(row_q);
    assign on_screen = (sx < 10'(SCREEN_W)) && (sy < 8'(SCREEN_H));

    assign rom_letter = text_l[{char_q, 2'b00} +: 4];
    assign rom_x      = 8'(col_q);
    assign rom_y      = 7'(row_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start && (num_clamped == 4'd0)) begin
                    state_next = DONE;
                end else if (accept) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                busy = 1'b1;
                if (last_pixel) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and scan counters: column fastest, then row, then glyph.
    always_ff @(posedge clk) begin
        if (reset) begin
            char_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            count_l  <= '0;
            text_l   <= '0;
            ox_l     <= '0;
            oy_l     <= '0;
            fg_l     <= '0;
            bg_l     <= '0;
            opaque_l <= 1'b0;
        end else if (accept) begin
            char_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            count_l  <= num_clamped;
            text_l   <= text;
            ox_l     <= origin_x;
            oy_l     <= origin_y;
            fg_l     <= fg_colour;
            bg_l     <= bg_colour;
            opaque_l <= opaque;
        end else if (in_draw && !last_pixel) begin
            col_q <= col_q + 3'd1;
            if (col_q == 3'd7) begin
                row_q <= row_q + 4'd1;
                if (row_q == 4'd15) begin
                    char_q <= char_q + IDX_W'(1);
                end
            end
        end
    end

    // One-stage plot pipeline: the ROM answer for this cycle's address is
    // turned into a write request visible on the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            plot   <= 1'b0;
            vga_x  <= '0;
            vga_y  <= '0;
            colour <= '0;
        end else begin
            plot   <= in_draw && on_screen && (rom_pixel || opaque_l);
            colour <= rom_pixel ? fg_l : bg_l;
            vga_x  <= sx[7:0];
            vga_y  <= sy[6:0];
        end
    end

endmodule

// File: tb/tb_text_string_renderer.sv
// Directed bench for text_string_renderer with a behavioural font ROM and a
// queue-based scoreboard checked by a forked plot monitor.
module tb_text_string_renderer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  num_chars;
    logic [31:0] text;
    logic [7:0]  origin_x;
    logic [6:0]  origin_y;
    logic [2:0]  fg_colour;
    logic [2:0]  bg_colour;
    logic        opaque;
    logic [3:0]  rom_letter;
    logic [7:0]  rom_x;
    logic [6:0]  rom_y;
    logic        rom_pixel;
    logic        busy;
    logic        plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  colour;
    logic        done;

    text_string_renderer #(.MAX_CHARS(8), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .reset(reset), .start(start), .num_chars(num_chars),
        .text(text), .origin_x(origin_x), .origin_y(origin_y),
        .fg_colour(fg_colour), .bg_colour(bg_colour), .opaque(opaque),
        .rom_letter(rom_letter), .rom_x(rom_x), .rom_y(rom_y),
        .rom_pixel(rom_pixel), .busy(busy), .plot(plot), .vga_x(vga_x),
        .vga_y(vga_y), .colour(colour), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Font: column 0 is the MSB of each row byte.
    logic [7:0] font [0:15][0:15];
    assign rom_pixel = font[rom_letter][rom_y[3:0]][3'd7 - rom_x[2:0]];

    logic [17:0] exp_q[$];
    int          checks;
    int          errors;
    int          plot_cnt;
    int          cyc;
    logic [14:0] first_xy;
    logic [14:0] last_xy;
    bit          seen_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_render(input int n, input logic [31:0] txt, input int ox, input int oy,
                               input logic [2:0] fg, input logic [2:0] bg, input logic op,
                               input int limit);
        int nc;
        nc = (n > 8) ? 8 : n;
        for (int c = 0; c < nc; c++) begin
            for (int r = 0; r < 16; r++) begin
                for (int k = 0; k < 8; k++) begin
                    logic [3:0] g;
                    logic       pix;
                    int         sx;
                    int         sy;
                    g   = txt[c*4 +: 4];
                    pix = font[g][r][7-k];
                    sx  = ox + 8*c + k;
                    sy  = oy + r;
                    if ((c*128 + r*8 + k) < limit && sx < 160 && sy < 120 && (pix || op))
                        exp_q.push_back({sx[7:0], sy[6:0], pix ? fg : bg});
                end
            end
        end
    endtask

    task automatic start_render(input int n, input logic [31:0] txt, input int ox, input int oy,
                                input logic [2:0] fg, input logic [2:0] bg, input logic op);
        @(negedge clk);
        num_chars = 4'(n);
        text      = txt;
        origin_x  = 8'(ox);
        origin_y  = 7'(oy);
        fg_colour = fg;
        bg_colour = bg;
        opaque    = op;
        start     = 1'b1;
        plot_cnt  = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, cyc, exp_cyc);
        @(negedge clk);
        check({name, "_done_one_cycle"}, done, 1'b0);
        check({name, "_busy_after"}, busy, 1'b0);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_plot"}, plot, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_vga_x"}, vga_x, 0);
        check({name, "_vga_y"}, vga_y, 0);
        check({name, "_colour"}, colour, 0);
        check({name, "_rom_letter"}, rom_letter, 0);
        check({name, "_rom_x"}, rom_x, 0);
        check({name, "_rom_y"}, rom_y, 0);
    endtask

    initial begin
        for (int g = 0; g < 16; g++)
            for (int r = 0; r < 16; r++)
                font[g][r] = 8'((g * 37 + r * 11) ^ 8'h5A);
        // "A": 39 set pixels, first at col 3 row 2, last at col 4 row 11.
        for (int r = 0; r < 16; r++) font[0][r] = 8'h00;
        font[0][2]  = 8'b00011000;
        font[0][3]  = 8'b00111100;
        font[0][4]  = 8'b01100110;
        font[0][5]  = 8'b01100110;
        font[0][6]  = 8'b01111110;
        font[0][7]  = 8'b01111110;
        font[0][8]  = 8'b01100110;
        font[0][9]  = 8'b01100110;
        font[0][10] = 8'b01100110;
        font[0][11] = 8'b00001000;
        for (int r = 0; r < 16; r++) font[7][r] = (r == 7) ? 8'b11111111 : 8'b11000011;
    end

    initial begin
        checks = 0; errors = 0; plot_cnt = 0; cyc = 0;
        first_xy = '0; last_xy = '0;
        reset = 1'b1; start = 1'b0; num_chars = '0; text = '0;
        origin_x = '0; origin_y = '0; fg_colour = '0; bg_colour = '0; opaque = 1'b0;

        // Plot monitor: every presented write must match the next expected entry.
        fork
            forever begin
                @(negedge clk);
                if (plot === 1'b1) begin
                    if (plot_cnt == 0) first_xy = {vga_x, vga_y};
                    last_xy = {vga_x, vga_y};
                    plot_cnt++;
                    check("plot_on_screen", 32'(vga_x < 8'd160 && vga_y < 7'd120), 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_plot", 1, 0);
                    end else begin
                        check("plot_xyc", {vga_x, vga_y, colour}, exp_q.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b0;

        // Single "A", transparent.
        push_render(1, 32'h0, 10, 20, 3'd7, 3'd0, 1'b0, 1 << 30);
        start_render(1, 32'h0, 10, 20, 3'd7, 3'd0, 1'b0);
        wait_done("a_done_cycle", 130);
        check("a_plot_count", plot_cnt, 39);
        check("a_first_xy", first_xy, {8'd13, 7'd22});
        check("a_last_xy", last_xy, {8'd14, 7'd31});

        // Two glyphs, opaque, at the origin.
        push_render(2, 32'h10, 0, 0, 3'd7, 3'd1, 1'b1, 1 << 30);
        start_render(2, 32'h10, 0, 0, 3'd7, 3'd1, 1'b1);
        wait_done("two_done_cycle", 258);
        check("two_plot_count", plot_cnt, 256);

        // "H" clipped at the bottom-right corner: 4 columns x 10 rows survive.
        push_render(1, 32'h7, 156, 110, 3'd5, 3'd2, 1'b1, 1 << 30);
        start_render(1, 32'h7, 156, 110, 3'd5, 3'd2, 1'b1);
        wait_done("clip_done_cycle", 130);
        check("clip_plot_count", plot_cnt, 40);

        // Empty string.
        @(negedge clk);
        check("empty_busy_idle", busy, 1'b0);
        start_render(0, 32'h0, 5, 5, 3'd7, 3'd0, 1'b1);
        check("empty_busy_in_done", busy, 1'b1);
        wait_done("empty_done_cycle", 1);
        check("empty_plot_count", plot_cnt, 0);

        // Oversized count clamps to eight glyphs.
        push_render(15, 32'h76543210, 100, 50, 3'd6, 3'd3, 1'b0, 1 << 30);
        start_render(15, 32'h76543210, 100, 50, 3'd6, 3'd3, 1'b0);
        wait_done("clamp_done_cycle", 1026);

        // Reset during DRAW cycle 50: only pixels 0..49 ever reach the output.
        push_render(2, 32'h10, 0, 0, 3'd7, 3'd1, 1'b1, 50);
        start_render(2, 32'h10, 0, 0, 3'd7, 3'd1, 1'b1);
        repeat (50) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("mid_reset_no_done", seen_done, 1'b0);
        check("mid_reset_plot_count", plot_cnt, 50);
        check("mid_reset_queue_drained", exp_q.size(), 0);

        push_render(1, 32'h0, 10, 20, 3'd7, 3'd0, 1'b0, 1 << 30);
        start_render(1, 32'h0, 10, 20, 3'd7, 3'd0, 1'b0);
        wait_done("after_reset_done_cycle", 130);
        check("after_reset_first_xy", first_xy, {8'd13, 7'd22});
        check("after_reset_plot_count", plot_cnt, 39);

        // A second start while busy is ignored.
        push_render(1, 32'h0, 10, 20, 3'd7, 3'd0, 1'b0, 1 << 30);
        start_render(1, 32'h0, 10, 20, 3'd7, 3'd0, 1'b0);
        while (!done && cyc < 3000) begin
            if (cyc == 10) begin
                text = 32'h7; num_chars = 4'd3; origin_x = 8'd40; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("restart_done_cycle", cyc, 130);
        check("restart_plot_count", plot_cnt, 39);
        check("restart_queue_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        check("restart_not_queued", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
